// File: rtl/fanout_broadcast_buffer_if.sv
// rtl/fanout_broadcast_buffer_if.sv - producer/consumer handshake bundle for the broadcast buffer
interface fanout_broadcast_buffer_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_LOADS = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_data;
    logic [NUM_LOADS-1:0]       out_valid;
    logic [NUM_LOADS-1:0]       out_ready;
    logic [NUM_LOADS*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fanout_broadcast_buffer.sv
// rtl/fanout_broadcast_buffer.sv - per-load FIFO broadcast stage with optional lossy drop accounting
module fanout_broadcast_buffer #(
    parameter int WIDTH     = 8,
    parameter int NUM_LOADS = 4,
    parameter int DEPTH     = 2,
    parameter int DROP_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fanout_broadcast_buffer_if.slave bus,
    input  logic [NUM_LOADS-1:0]     load_mask,
    input  logic                     clear_drops,
    output logic [NUM_LOADS-1:0]     drop_flag,
    output logic [15:0]              drop_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic                 run_q, run_d;
    logic [CW-1:0]        count_q [NUM_LOADS];
    logic [CW-1:0]        count_d [NUM_LOADS];
    logic [PW-1:0]        wr_q    [NUM_LOADS];
    logic [PW-1:0]        wr_d    [NUM_LOADS];
    logic [PW-1:0]        rd_q    [NUM_LOADS];
    logic [PW-1:0]        rd_d    [NUM_LOADS];
    logic [WIDTH-1:0]     mem_q   [NUM_LOADS][DEPTH];
    logic [WIDTH-1:0]     mem_d   [NUM_LOADS][DEPTH];
    logic [NUM_LOADS-1:0] drop_flag_q, drop_flag_d;
    logic [15:0]          drop_count_q, drop_count_d;

    logic [NUM_LOADS-1:0] full, push, pop, drop;
    logic                 accept;
    logic [15:0]          n_drop;
    logic [16:0]          drop_sum;

    always_comb begin
        full          = '0;
        pop           = '0;
        bus.out_valid = '0;
        bus.out_data  = '0;
        for (int i = 0; i < NUM_LOADS; i++) begin
            full[i]                           = (count_q[i] == CW'(DEPTH));
            bus.out_valid[i]                  = (count_q[i] != '0);
            pop[i]                            = (count_q[i] != '0) & bus.out_ready[i];
            bus.out_data[i*WIDTH +: WIDTH]    = mem_q[i][rd_q[i]];
        end
    end

    // Readiness looks only at registered fullness, so a same-cycle pop never opens the gate.
    assign bus.in_ready = run_q & ((DROP_MODE != 0) | ~|(load_mask & full));
    assign accept       = bus.in_valid & bus.in_ready;
    assign push         = {NUM_LOADS{accept}} & load_mask & ~full;
    assign drop         = (DROP_MODE != 0) ? ({NUM_LOADS{accept}} & load_mask & full) : '0;

    always_comb begin
        run_d        = 1'b1;
        count_d      = count_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        mem_d        = mem_q;
        drop_flag_d  = drop_flag_q | drop;
        n_drop       = '0;
        for (int i = 0; i < NUM_LOADS; i++) begin
            if (push[i]) begin
                mem_d[i][wr_q[i]] = bus.in_data;
                wr_d[i]           = wr_q[i] + PW'(1);
            end
            if (pop[i]) begin
                rd_d[i] = rd_q[i] + PW'(1);
            end
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CW'(1);
                2'b01:   count_d[i] = count_q[i] - CW'(1);
                default: count_d[i] = count_q[i];
            endcase
            n_drop = n_drop + 16'(drop[i]);
        end
        drop_sum     = {1'b0, drop_count_q} + {1'b0, n_drop};
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (clear_drops) begin
            drop_flag_d  = '0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            count_q      <= '{default: '0};
            wr_q         <= '{default: '0};
            rd_q         <= '{default: '0};
            mem_q        <= '{default: '{default: '0}};
            drop_flag_q  <= '0;
            drop_count_q <= '0;
        end else begin
            run_q        <= run_d;
            count_q      <= count_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            mem_q        <= mem_d;
            drop_flag_q  <= drop_flag_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_flag  = drop_flag_q;
    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_fanout_broadcast_buffer.sv
// tb/tb_fanout_broadcast_buffer.sv - directed bench for lossless and lossy broadcast buffers
module tb_fanout_broadcast_buffer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] l_mask, y_mask;
    logic       l_clr, y_clr;
    logic [3:0] l_flag, y_flag;
    logic [15:0] l_dcnt, y_dcnt;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fanout_broadcast_buffer_if #(.WIDTH(8), .NUM_LOADS(4)) l_bus ();
    fanout_broadcast_buffer_if #(.WIDTH(8), .NUM_LOADS(4)) y_bus ();

    fanout_broadcast_buffer #(.WIDTH(8), .NUM_LOADS(4), .DEPTH(2), .DROP_MODE(0)) dut_lossless (
        .clk(clk), .rst_n(rst_n), .bus(l_bus), .load_mask(l_mask),
        .clear_drops(l_clr), .drop_flag(l_flag), .drop_count(l_dcnt)
    );

    fanout_broadcast_buffer #(.WIDTH(8), .NUM_LOADS(4), .DEPTH(2), .DROP_MODE(1)) dut_lossy (
        .clk(clk), .rst_n(rst_n), .bus(y_bus), .load_mask(y_mask),
        .clear_drops(y_clr), .drop_flag(y_flag), .drop_count(y_dcnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        l_bus.in_valid = 1'b0; l_bus.in_data = '0; l_bus.out_ready = '0; l_mask = 4'hF; l_clr = 1'b0;
        y_bus.in_valid = 1'b0; y_bus.in_data = '0; y_bus.out_ready = '0; y_mask = 4'hF; y_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (l_bus.out_valid !== 4'h0) begin n_bad++; $display("FAIL rst_out_valid got=%h exp=0", l_bus.out_valid); end
        n_cmp++; if (l_bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=0", l_bus.in_ready); end
        n_cmp++; if (y_flag !== 4'h0) begin n_bad++; $display("FAIL rst_drop_flag got=%h exp=0", y_flag); end
        n_cmp++; if (y_dcnt !== 16'h0) begin n_bad++; $display("FAIL rst_drop_count got=%h exp=0", y_dcnt); end
        n_cmp++; if (l_flag !== 4'h0 || l_dcnt !== 16'h0) begin n_bad++; $display("FAIL rst_lossless_stats got=%h/%h exp=0/0", l_flag, l_dcnt); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (l_bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rel_in_ready_early got=%b exp=0", l_bus.in_ready); end
        step();
        n_cmp++; if (l_bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rel_in_ready got=%b exp=1", l_bus.in_ready); end
        n_cmp++; if (y_bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rel_lossy_in_ready got=%b exp=1", y_bus.in_ready); end
    endtask

    task automatic test_broadcast();
        l_mask = 4'hF; l_bus.out_ready = 4'hF;
        l_bus.in_valid = 1'b1; l_bus.in_data = 8'hA5;
        #1;
        n_cmp++; if (l_bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bc_in_ready got=%b exp=1", l_bus.in_ready); end
        step();
        l_bus.in_valid = 1'b0;
        n_cmp++; if (l_bus.out_valid !== 4'hF) begin n_bad++; $display("FAIL bc_out_valid got=%h exp=f", l_bus.out_valid); end
        n_cmp++; if (l_bus.out_data !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL bc_out_data got=%h exp=a5a5a5a5", l_bus.out_data); end
        step();
        n_cmp++; if (l_bus.out_valid !== 4'h0) begin n_bad++; $display("FAIL bc_drained got=%h exp=0", l_bus.out_valid); end
    endtask

    task automatic test_backpressure();
        l_mask = 4'hF; l_bus.out_ready = 4'b1011;
        l_bus.in_valid = 1'b1; l_bus.in_data = 8'h11;
        #1;
        n_cmp++; if (l_bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_beat1 got=%b exp=1", l_bus.in_ready); end
        step();
        l_bus.in_data = 8'h22;
        #1;
        n_cmp++; if (l_bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_beat2 got=%b exp=1", l_bus.in_ready); end
        n_cmp++; if (l_bus.out_data[23:16] !== 8'h11) begin n_bad++; $display("FAIL bp_lane2_first got=%h exp=11", l_bus.out_data[23:16]); end
        step();
        l_bus.in_data = 8'h33;
        #1;
        n_cmp++; if (l_bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_rdy_full got=%b exp=0", l_bus.in_ready); end
        n_cmp++; if (l_bus.out_data[7:0] !== 8'h22) begin n_bad++; $display("FAIL bp_lane0_second got=%h exp=22", l_bus.out_data[7:0]); end
        step();
        n_cmp++; if (l_bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_rdy_held got=%b exp=0", l_bus.in_ready); end
        n_cmp++; if (l_bus.out_valid !== 4'b0100) begin n_bad++; $display("FAIL bp_valid_only2 got=%h exp=4", l_bus.out_valid); end
        l_bus.out_ready = 4'hF;
        #1;
        n_cmp++; if (l_bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_no_comb_path got=%b exp=0", l_bus.in_ready); end
        step();
        n_cmp++; if (l_bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_reopen got=%b exp=1", l_bus.in_ready); end
        n_cmp++; if (l_bus.out_data[23:16] !== 8'h22) begin n_bad++; $display("FAIL bp_lane2_second got=%h exp=22", l_bus.out_data[23:16]); end
        step();
        l_bus.in_valid = 1'b0;
        n_cmp++; if (l_bus.out_valid !== 4'hF) begin n_bad++; $display("FAIL bp_third_valid got=%h exp=f", l_bus.out_valid); end
        n_cmp++; if (l_bus.out_data !== 32'h33333333) begin n_bad++; $display("FAIL bp_third_data got=%h exp=33333333", l_bus.out_data); end
        step();
        n_cmp++; if (l_bus.out_valid !== 4'h0) begin n_bad++; $display("FAIL bp_drained got=%h exp=0", l_bus.out_valid); end
    endtask

    task automatic test_lossy();
        y_mask = 4'hF; y_bus.out_ready = 4'b1101;
        for (int k = 1; k <= 5; k++) begin
            y_bus.in_valid = 1'b1; y_bus.in_data = 8'(k);
            #1;
            n_cmp++; if (y_bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL ly_in_ready beat=%0d got=%b exp=1", k, y_bus.in_ready); end
            step();
            n_cmp++; if (y_bus.out_data[7:0] !== 8'(k) || y_bus.out_data[31:24] !== 8'(k)) begin n_bad++; $display("FAIL ly_order beat=%0d got=%h exp=%h", k, y_bus.out_data, k); end
        end
        y_bus.in_valid = 1'b0;
        n_cmp++; if (y_flag !== 4'b0010) begin n_bad++; $display("FAIL ly_drop_flag got=%b exp=0010", y_flag); end
        n_cmp++; if (y_dcnt !== 16'd3) begin n_bad++; $display("FAIL ly_drop_count got=%0d exp=3", y_dcnt); end
        n_cmp++; if (y_bus.out_data[15:8] !== 8'h01) begin n_bad++; $display("FAIL ly_lane1_head got=%h exp=01", y_bus.out_data[15:8]); end
        step();
        n_cmp++; if (y_bus.out_valid !== 4'b0010) begin n_bad++; $display("FAIL ly_only1_left got=%b exp=0010", y_bus.out_valid); end
        y_bus.out_ready = 4'hF;
        step();
        n_cmp++; if (y_bus.out_data[15:8] !== 8'h02) begin n_bad++; $display("FAIL ly_lane1_second got=%h exp=02", y_bus.out_data[15:8]); end
        step();
        n_cmp++; if (y_bus.out_valid !== 4'h0) begin n_bad++; $display("FAIL ly_drained got=%h exp=0", y_bus.out_valid); end
    endtask

    task automatic test_mask();
        l_mask = 4'b0101; l_bus.out_ready = 4'h0;
        l_bus.in_valid = 1'b1; l_bus.in_data = 8'h3C;
        step();
        l_bus.in_valid = 1'b0;
        n_cmp++; if (l_bus.out_valid !== 4'b0101) begin n_bad++; $display("FAIL mk_valid got=%b exp=0101", l_bus.out_valid); end
        n_cmp++; if (l_bus.out_data[7:0] !== 8'h3C || l_bus.out_data[23:16] !== 8'h3C) begin n_bad++; $display("FAIL mk_data got=%h exp=xx3cxx3c", l_bus.out_data); end
        l_bus.out_ready = 4'hF; l_mask = 4'h0;
        l_bus.in_valid = 1'b1; l_bus.in_data = 8'h77;
        #1;
        n_cmp++; if (l_bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mk_zero_ready got=%b exp=1", l_bus.in_ready); end
        step();
        l_bus.in_valid = 1'b0;
        n_cmp++; if (l_bus.out_valid !== 4'h0) begin n_bad++; $display("FAIL mk_zero_discard got=%b exp=0000", l_bus.out_valid); end
    endtask

    task automatic test_wrap();
        l_mask = 4'b0001; l_bus.out_ready = 4'h0;
        l_bus.in_valid = 1'b1; l_bus.in_data = 8'hA0;
        step();
        l_bus.in_data = 8'hA1;
        #1;
        n_cmp++; if (l_bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL wr_rdy_one got=%b exp=1", l_bus.in_ready); end
        step();
        l_bus.in_data = 8'hA2;
        #1;
        n_cmp++; if (l_bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL wr_rdy_full got=%b exp=0", l_bus.in_ready); end
        n_cmp++; if (l_bus.out_data[7:0] !== 8'hA0) begin n_bad++; $display("FAIL wr_head0 got=%h exp=a0", l_bus.out_data[7:0]); end
        l_bus.out_ready = 4'hF;
        #1;
        n_cmp++; if (l_bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL wr_full_pop_blocks got=%b exp=0", l_bus.in_ready); end
        step();
        n_cmp++; if (l_bus.out_data[7:0] !== 8'hA1) begin n_bad++; $display("FAIL wr_head1 got=%h exp=a1", l_bus.out_data[7:0]); end
        for (int k = 2; k <= 5; k++) begin
            l_bus.in_data = 8'hA0 + 8'(k);
            step();
            n_cmp++; if (l_bus.out_data[7:0] !== 8'hA0 + 8'(k) || l_bus.out_valid !== 4'b0001) begin n_bad++; $display("FAIL wr_stream beat=%0d got=%h/%b exp=%h/0001", k, l_bus.out_data[7:0], l_bus.out_valid, 8'hA0 + 8'(k)); end
        end
        l_bus.in_valid = 1'b0;
        step();
        n_cmp++; if (l_bus.out_valid !== 4'h0) begin n_bad++; $display("FAIL wr_drained got=%b exp=0000", l_bus.out_valid); end
    endtask

    task automatic test_lossy_full_pop();
        y_mask = 4'b0001; y_bus.out_ready = 4'h0;
        y_bus.in_valid = 1'b1; y_bus.in_data = 8'hC0;
        step();
        y_bus.in_data = 8'hC1;
        step();
        y_bus.in_data = 8'hC2; y_bus.out_ready = 4'b0001;
        #1;
        n_cmp++; if (y_bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL lf_in_ready got=%b exp=1", y_bus.in_ready); end
        step();
        y_bus.in_valid = 1'b0;
        n_cmp++; if (y_bus.out_data[7:0] !== 8'hC1 || y_bus.out_valid !== 4'b0001) begin n_bad++; $display("FAIL lf_head got=%h/%b exp=c1/0001", y_bus.out_data[7:0], y_bus.out_valid); end
        n_cmp++; if (y_dcnt !== 16'd4) begin n_bad++; $display("FAIL lf_drop_count got=%0d exp=4", y_dcnt); end
        n_cmp++; if (y_flag !== 4'b0011) begin n_bad++; $display("FAIL lf_drop_flag got=%b exp=0011", y_flag); end
        step();
        n_cmp++; if (y_bus.out_valid !== 4'h0) begin n_bad++; $display("FAIL lf_drained got=%b exp=0000 (dropped beat enqueued)", y_bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        l_mask = 4'hF; l_bus.out_ready = 4'h0;
        l_bus.in_valid = 1'b1; l_bus.in_data = 8'hD0;
        step();
        l_bus.in_data = 8'hD1;
        step();
        l_bus.in_valid = 1'b0;
        n_cmp++; if (l_bus.out_valid !== 4'hF) begin n_bad++; $display("FAIL rm_queued got=%b exp=1111", l_bus.out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (l_bus.out_valid !== 4'h0) begin n_bad++; $display("FAIL rm_async_valid got=%b exp=0000", l_bus.out_valid); end
        n_cmp++; if (l_bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rm_async_ready got=%b exp=0", l_bus.in_ready); end
        n_cmp++; if (y_dcnt !== 16'd0 || y_flag !== 4'h0) begin n_bad++; $display("FAIL rm_stats_cleared got=%h/%b exp=0/0000", y_dcnt, y_flag); end
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (l_bus.in_ready !== 1'b1 || l_bus.out_valid !== 4'h0) begin n_bad++; $display("FAIL rm_no_stale got=%b/%b exp=1/0000", l_bus.in_ready, l_bus.out_valid); end
        y_mask = 4'b0001; y_bus.out_ready = 4'h0;
        y_bus.in_valid = 1'b1; y_bus.in_data = 8'hE0;
        step();
        y_bus.in_data = 8'hE1;
        step();
        y_bus.in_data = 8'hE2;
        step();
        n_cmp++; if (y_dcnt !== 16'd1 || y_flag !== 4'b0001) begin n_bad++; $display("FAIL rm_drop_before_clear got=%0d/%b exp=1/0001", y_dcnt, y_flag); end
        y_bus.in_data = 8'hE3; y_clr = 1'b1;
        step();
        y_clr = 1'b0; y_bus.in_valid = 1'b0;
        n_cmp++; if (y_dcnt !== 16'd0) begin n_bad++; $display("FAIL rm_clear_wins_count got=%0d exp=0", y_dcnt); end
        n_cmp++; if (y_flag !== 4'h0) begin n_bad++; $display("FAIL rm_clear_wins_flag got=%b exp=0000", y_flag); end
        n_cmp++; if (y_bus.out_data[7:0] !== 8'hE0) begin n_bad++; $display("FAIL rm_lossy_head got=%h exp=e0", y_bus.out_data[7:0]); end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_backpressure();
        test_lossy();
        test_mask();
        test_wrap();
        test_lossy_full_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
